// File: rtl/mips_pkg.sv
// Shared definitions for the instruction fetch path: FSM states, field widths
// and the default reset vector.
package mips_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } state_t;

    localparam int OPC_W  = 6;
    localparam int FUNC_W = 6;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_next_pc.sv
// Combinational next-PC selection: jump-register, jump, taken branch or
// sequential, in that priority order.
module next_pc #(
    parameter int AW = 32
) (
    input  logic [AW-1:0] pc_plus4,
    input  logic [25:0]   imm26,
    input  logic [AW-1:0] jr_addr,
    input  logic          pcsrc,
    input  logic          pc1,
    input  logic          pc2,
    output logic [AW-1:0] npc
);

    logic [AW-1:0] jr_target;
    logic [AW-1:0] jump_target;
    logic [AW-1:0] branch_off;

    assign jr_target = jr_addr & ~AW'(3);

    // Jump keeps the upper nibble of pc_plus4 and replaces the low 28 bits.
    assign jump_target = (pc_plus4 & ~AW'(32'h0FFF_FFFF)) | AW'({imm26, 2'b00});

    assign branch_off = AW'($signed({imm26[15:0], 2'b00}));

    always_comb begin
        npc = pc_plus4;
        if (pc2) begin
            npc = jr_target;
        end else if (pc1) begin
            npc = jump_target;
        end else if (pcsrc) begin
            npc = pc_plus4 + branch_off;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Two-state instruction fetch unit: requests a word at pc, latches it, holds it
// for the datapath and then advances pc when execution completes.
module fetch_unit
    import mips_pkg::*;
#(
    parameter int            AW       = 32,
    parameter logic [AW-1:0] RESET_PC = AW'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [AW-1:0]     imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic [OPC_W-1:0]  opc,
    output logic [FUNC_W-1:0] func,
    output logic              instr_valid,
    input  logic              exec_done,
    input  logic              pcsrc,
    input  logic              pc1,
    input  logic              pc2,
    input  logic [AW-1:0]     jr_addr,
    output logic [AW-1:0]     pc,
    output logic [AW-1:0]     pc_plus4
);

    state_t        state;
    logic [AW-1:0] npc;

    assign imem_req    = (state == FETCH);
    assign instr_valid = (state == EXEC);
    assign imem_addr   = pc;
    assign pc_plus4    = pc + AW'(4);
    assign opc         = instr[31:26];
    assign func        = instr[5:0];

    next_pc #(.AW(AW)) u_next_pc (
        .pc_plus4 (pc_plus4),
        .imm26    (instr[25:0]),
        .jr_addr  (jr_addr),
        .pcsrc    (pcsrc),
        .pc1      (pc1),
        .pc2      (pc2),
        .npc      (npc)
    );

    // Reset wins over everything, so a read completing in the reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            pc    <= RESET_PC;
            instr <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ready) begin
                        instr <= imem_rdata;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (exec_done) begin
                        pc    <= npc;
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule
